// File: rtl/fb_painter_pkg.sv
// fb_pkg: shared types and constants for the double-buffered framebuffer painter.
//   rgb444_t      : packed {b,g,r} 4-bit pixel, matching the writer's wr_rgb layout
//   fb_state_t    : writer-side FSM states (IDLE, CLEAR, SWAP_WAIT)
//   FB_W / FB_H   : panel size in pixels
//   HALF_DEPTH    : words per half-panel RAM (32 rows x 64 columns)
//   GAMMA_LUT     : 4-bit to 8-bit gamma table (gamma ~2.2), used only when
//                   FB_PAINTER_GAMMA_EN is defined
package fb_pkg;

    localparam int FB_W       = 64;
    localparam int FB_H       = 64;
    localparam int HALF_DEPTH = 2048;

    localparam int X_W    = $clog2(FB_W);
    localparam int Y_W    = $clog2(FB_H);
    localparam int ADDR_W = $clog2(HALF_DEPTH);

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } rgb444_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SWAP_WAIT
    } fb_state_t;

    // Entry 15 sits in the top byte, entry 0 in the bottom byte.
    localparam logic [8*16-1:0] GAMMA_LUT = {
        8'd255, 8'd219, 8'd186, 8'd156, 8'd129, 8'd105, 8'd83, 8'd64,
        8'd48,  8'd34,  8'd23,  8'd14,  8'd7,   8'd3,   8'd1,  8'd0
    };

    function automatic logic [7:0] gamma_lookup(input logic [3:0] level);
        return GAMMA_LUT[{level, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fb_painter_if.sv
// fb_painter_if: host-side writer port of the framebuffer painter.
//   wr_valid/wr_ready : pixel write handshake, a write happens when both are high
//   wr_x, wr_y        : pixel coordinates, wr_y[5] selects the bottom half
//   wr_rgb            : {b4,g4,r4} pixel colour
//   clear_req         : one-cycle pulse, fill the back buffer with the clear colour
//   swap_req          : one-cycle pulse, swap buffers at the next frame boundary
//   swap_done         : one-cycle pulse on the cycle the swap takes effect
// master is the host side, slave is fb_painter.
interface fb_painter_if;
    import fb_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [X_W-1:0]   wr_x;
    logic [Y_W-1:0]   wr_y;
    rgb444_t          wr_rgb;
    logic             clear_req;
    logic             swap_req;
    logic             swap_done;

    modport master (
        output wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req,
        input  wr_ready, swap_done
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req,
        output wr_ready, swap_done
    );
endinterface

// File: rtl/fb_bank_ram.sv
// fb_bank_ram: one 2048 x 12 simple dual-port RAM (one half of one bank).
//   clk   : clock
//   we    : write enable
//   waddr : write address {y[4:0], x}
//   wdata : pixel to store
//   raddr : read address {addr, x}
//   rdata : registered read data, valid one cycle after raddr
// Contents are not reset so the array maps onto block RAM.
module fb_bank_ram
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  rgb444_t           wdata,
    input  logic [ADDR_W-1:0] raddr,
    output rgb444_t           rdata
);

    rgb444_t mem [HALF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fb_painter.sv
// fb_painter: double-buffered 64x64 RGB444 framebuffer feeding the HUB75 driver.
//   clk, reset      : clock, synchronous active-high reset
//   frame           : driver frame counter, any change marks a frame boundary
//   subframe        : driver PWM subframe index
//   x, addr         : pixel being fetched (top row {0,addr}, bottom row {1,addr})
//   rgb0, rgb1      : {b,g,r} on-bits for top/bottom pixel, 2 cycles after x/addr
//   wr              : writer port (fb_painter_if.slave)
// Parameter CLEAR_RGB is the fill colour of the clear command.
// Define FB_PAINTER_GAMMA_EN to pass each channel through the gamma table and
// compare against the full subframe; otherwise channels compare linearly
// against subframe[7:4].
module fb_painter
    import fb_pkg::*;
#(
    parameter logic [11:0] CLEAR_RGB = 12'h000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [12:0]      frame,
    input  logic [7:0]       subframe,
    input  logic [X_W-1:0]   x,
    input  logic [4:0]       addr,
    output logic [2:0]       rgb0,
    output logic [2:0]       rgb1,
    fb_painter_if.slave      wr
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(HALF_DEPTH - 1);

`ifdef FB_PAINTER_GAMMA_EN
    localparam int SF_W = 8;

    function automatic logic on_bit(input logic [3:0] level, input logic [SF_W-1:0] sf);
        return gamma_lookup(level) > sf;
    endfunction
`else
    localparam int SF_W = 4;

    logic unused_subframe_lsbs;
    assign unused_subframe_lsbs = ^subframe[3:0];

    function automatic logic on_bit(input logic [3:0] level, input logic [SF_W-1:0] sf);
        return level > sf;
    endfunction
`endif

    function automatic logic [2:0] modulate(input rgb444_t px, input logic [SF_W-1:0] sf);
        return {on_bit(px.b, sf), on_bit(px.g, sf), on_bit(px.r, sf)};
    endfunction

    fb_state_t         state, state_next;
    logic              front, front_next;
    logic              swap_pend, swap_pend_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic [12:0]       frame_q;
    logic              ready_c, swap_c;

    logic [1:0][1:0]   ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    rgb444_t           ram_wdata;
    logic [ADDR_W-1:0] rd_addr;
    rgb444_t           ram_rdata [2][2];

    logic              front_d1;
    logic [SF_W-1:0]   sub_d1;
    rgb444_t           top_px, bot_px;

    // Writer FSM: accepts pixels in IDLE, sweeps the back bank in CLEAR and
    // holds off in SWAP_WAIT until the driver's frame counter moves. A swap
    // requested alongside or during a clear is remembered in swap_pend.
    always_comb begin
        state_next     = state;
        front_next     = front;
        swap_pend_next = swap_pend;
        clr_cnt_next   = clr_cnt;
        ready_c        = 1'b0;
        swap_c         = 1'b0;
        unique case (state)
            IDLE: begin
                ready_c      = 1'b1;
                clr_cnt_next = '0;
                if (wr.clear_req) begin
                    state_next     = CLEAR;
                    swap_pend_next = wr.swap_req;
                end else if (wr.swap_req) begin
                    state_next = SWAP_WAIT;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (wr.swap_req) begin
                    swap_pend_next = 1'b1;
                end
                if (clr_cnt == CLR_LAST) begin
                    if (swap_pend || wr.swap_req) begin
                        state_next     = SWAP_WAIT;
                        swap_pend_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            SWAP_WAIT: begin
                if (frame != frame_q) begin
                    front_next = ~front;
                    swap_c     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wr.wr_ready  = ready_c;
    // Masked during reset so an aborted SWAP_WAIT can never report a swap.
    assign wr.swap_done = swap_c & ~reset;

    // frame_q reloads during reset so the first cycle out of reset is never
    // mistaken for a boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            front     <= 1'b0;
            swap_pend <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            state     <= state_next;
            front     <= front_next;
            swap_pend <= swap_pend_next;
            clr_cnt   <= clr_cnt_next;
        end
        frame_q <= frame;
    end

    // Write steering: the clear sweep drives both halves of the back bank at
    // the same address; a normal write hits only the half chosen by wr_y[5].
    always_comb begin
        ram_we    = '0;
        ram_waddr = {wr.wr_y[4:0], wr.wr_x};
        ram_wdata = wr.wr_rgb;
        if (!reset) begin
            if (state == CLEAR) begin
                ram_waddr        = clr_cnt;
                ram_wdata        = CLEAR_RGB;
                ram_we[~front]   = 2'b11;
            end else if (wr.wr_valid && ready_c) begin
                ram_we[~front][wr.wr_y[Y_W-1]] = 1'b1;
            end
        end
    end

    assign rd_addr = {addr, x};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            fb_bank_ram u_ram (
                .clk   (clk),
                .we    (ram_we[b][h]),
                .waddr (ram_waddr),
                .wdata (ram_wdata),
                .raddr (rd_addr),
                .rdata (ram_rdata[b][h])
            );
        end
    end

    // front_d1 remembers which bank was front when the coordinates were
    // presented, so a swap never mixes banks inside one fetch.
    assign top_px = front_d1 ? ram_rdata[1][0] : ram_rdata[0][0];
    assign bot_px = front_d1 ? ram_rdata[1][1] : ram_rdata[0][1];

    // Read pipeline: stage 1 is the RAM read (plus aligned front/subframe),
    // stage 2 is the compare into the output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_d1 <= 1'b0;
            sub_d1   <= '0;
            rgb0     <= '0;
            rgb1     <= '0;
        end else begin
            front_d1 <= front;
            sub_d1   <= subframe[7 -: SF_W];
            rgb0     <= modulate(top_px, sub_d1);
            rgb1     <= modulate(bot_px, sub_d1);
        end
    end

endmodule

// File: tb/tb_fb_painter.sv
// tb_fb_painter: self-checking bench for fb_painter (default build, linear
// modulation). A bank/pixel array model predicts what the display shows;
// a table covers hand-computed pixel/subframe cases, and hand sequences cover
// clear, swap timing, writes during display and reset inside SWAP_WAIT.
module tb_fb_painter;
    import fb_pkg::*;

    localparam logic [11:0] CLEAR_C = 12'h5A3;

    typedef struct {
        logic [5:0]  px;
        logic [4:0]  pa;
        logic [11:0] top;
        logic [11:0] bot;
        logic [7:0]  sf;
        logic [2:0]  exp0;
        logic [2:0]  exp1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x;
    logic [4:0]  addr;
    logic [2:0]  rgb0, rgb1;

    fb_painter_if bus ();

    fb_painter #(.CLEAR_RGB(CLEAR_C)) dut (
        .clk      (clk),
        .reset    (reset),
        .frame    (frame),
        .subframe (subframe),
        .x        (x),
        .addr     (addr),
        .rgb0     (rgb0),
        .rgb1     (rgb1),
        .wr       (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          swap_cnt = 0;
    logic        model_front;
    logic [11:0] model_mem [2][4096];
    vec_t        vecs [10];

    int          start, low, bad, on_cnt;
    logic [2:0]  r0, r1;
    logic [31:0] rv;
    logic [5:0]  rx;
    logic [5:0]  ry;
    logic [7:0]  sf;
    logic [11:0] rnd_px [$];

    always @(posedge clk) begin
        if (bus.swap_done === 1'b1) swap_cnt <= swap_cnt + 1;
    end

    // Display rule: a channel is on when its level exceeds subframe/16.
    function automatic logic [2:0] exp_bits(input logic [11:0] px, input logic [7:0] s);
        int th, cb, cg, cr;
        th = int'(s) / 16;
        cb = int'(px[11:8]);
        cg = int'(px[7:4]);
        cr = int'(px[3:0]);
        return {cb > th, cg > th, cr > th};
    endfunction

    function automatic int pix_index(input int px, input int py);
        return py * 64 + px;
    endfunction

    task automatic checkOutput(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic writePixel(input logic [5:0] px, input logic [5:0] py, input logic [11:0] val);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_x     = px;
        bus.wr_y     = py;
        bus.wr_rgb   = val;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        model_mem[!model_front][pix_index(px, py)] = val;
    endtask

    task automatic readPixel(input logic [5:0] px, input logic [4:0] pa, input logic [7:0] s,
                             output logic [2:0] o0, output logic [2:0] o1);
        @(negedge clk);
        x        = px;
        addr     = pa;
        subframe = s;
        @(negedge clk);
        @(negedge clk);
        o0 = rgb0;
        o1 = rgb1;
    endtask

    task automatic checkModelPixel(input string name, input logic [5:0] px, input logic [4:0] pa,
                                   input logic [7:0] s);
        logic [2:0] o0, o1;
        readPixel(px, pa, s, o0, o1);
        checkOutput({name, " rgb0"}, o0, exp_bits(model_mem[model_front][pix_index(px, pa)], s));
        checkOutput({name, " rgb1"}, o1, exp_bits(model_mem[model_front][pix_index(px, 32 + pa)], s));
    endtask

    task automatic requestSwap();
        @(negedge clk);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
    endtask

    // Called at a negedge while the DUT waits for a boundary.
    task automatic completeSwap(input string name, input int base);
        checkOutput({name, " no early swap"}, swap_cnt - base, 0);
        frame = frame + 13'd1;
        #1;
        checkOutput({name, " swap_done on boundary"}, bus.swap_done, 1);
        @(negedge clk);
        checkOutput({name, " single pulse"}, swap_cnt - base, 1);
        checkOutput({name, " swap_done low after"}, bus.swap_done, 0);
        model_front = !model_front;
    endtask

    task automatic modelClearBack();
        for (int i = 0; i < 4096; i++) model_mem[!model_front][i] = CLEAR_C;
    endtask

    task automatic applyStimulus(input vec_t v);
        writePixel(v.px, {1'b0, v.pa}, v.top);
        writePixel(v.px, {1'b1, v.pa}, v.bot);
    endtask

    initial begin
        // wr_rgb packs {b,g,r}, so 12'hF00 is full blue and 12'h00F full red.
        vecs[0] = '{6'd5,  5'd3,  12'hF00, 12'h00F, 8'h00, 3'b100, 3'b001};
        vecs[1] = '{6'd5,  5'd3,  12'hF00, 12'h00F, 8'hEF, 3'b100, 3'b001};
        vecs[2] = '{6'd5,  5'd3,  12'hF00, 12'h00F, 8'hF0, 3'b000, 3'b000};
        vecs[3] = '{6'd10, 5'd0,  12'h008, 12'h888, 8'h70, 3'b001, 3'b111};
        vecs[4] = '{6'd10, 5'd0,  12'h008, 12'h888, 8'h80, 3'b000, 3'b000};
        vecs[5] = '{6'd63, 5'd31, 12'h123, 12'hFFF, 8'h10, 3'b011, 3'b111};
        vecs[6] = '{6'd63, 5'd31, 12'h123, 12'hFFF, 8'h2F, 3'b001, 3'b111};
        vecs[7] = '{6'd0,  5'd0,  12'h000, 12'hA5C, 8'h00, 3'b000, 3'b111};
        vecs[8] = '{6'd0,  5'd0,  12'h000, 12'hA5C, 8'h55, 3'b000, 3'b101};
        vecs[9] = '{6'd0,  5'd0,  12'h000, 12'hA5C, 8'hB0, 3'b000, 3'b001};

        reset         = 1'b1;
        frame         = '0;
        subframe      = '0;
        x             = '0;
        addr          = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_rgb    = '0;
        bus.clear_req = 1'b0;
        bus.swap_req  = 1'b0;
        model_front   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset wr_ready", bus.wr_ready, 1);
        checkOutput("reset swap_done", bus.swap_done, 0);
        checkOutput("reset rgb0", rgb0, 0);
        checkOutput("reset rgb1", rgb1, 0);

        // Plain clear: busy for exactly one pass over 2048 addresses
        @(negedge clk);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        low = 0;
        while (bus.wr_ready !== 1'b1 && low < 3000) begin
            low++;
            @(negedge clk);
        end
        checkOutput("clear busy cycles", low, 2048);
        modelClearBack();
        start = swap_cnt;
        requestSwap();
        repeat (2) @(negedge clk);
        completeSwap("clear swap", start);

        // Stream every address of the new front bank and compare 2 cycles later
        bad = 0;
        for (int i = 0; i < 2050; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                if (rgb0 !== exp_bits(CLEAR_C, 8'h40) || rgb1 !== exp_bits(CLEAR_C, 8'h40)) bad++;
            end
            if (i < 2048) begin
                x        = i[5:0];
                addr     = i[10:6];
                subframe = 8'h40;
            end
        end
        checkOutput("cleared pixels wrong", bad, 0);

        // Clear and swap together: a boundary during the clear must not swap
        start = swap_cnt;
        @(negedge clk);
        bus.clear_req = 1'b1;
        bus.swap_req  = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        bus.swap_req  = 1'b0;
        for (int i = 0; i < 2052; i++) begin
            if (i == 1000) frame = frame + 13'd1;
            @(negedge clk);
        end
        checkOutput("clear+swap still waiting", bus.wr_ready, 0);
        modelClearBack();
        completeSwap("clear+swap", start);
        checkModelPixel("clear+swap pixel", 6'd33, 5'd17, 8'h30);

        // Table of hand-computed pixels
        foreach (vecs[i]) applyStimulus(vecs[i]);
        start = swap_cnt;
        requestSwap();
        completeSwap("table swap", start);
        foreach (vecs[i]) begin
            readPixel(vecs[i].px, vecs[i].pa, vecs[i].sf, r0, r1);
            checkOutput($sformatf("vec%0d rgb0", i), r0, vecs[i].exp0);
            checkOutput($sformatf("vec%0d rgb1", i), r1, vecs[i].exp1);
        end

        // Level 8 red: on for subframe[7:4] 0..7, off for 8..15
        writePixel(6'd20, 6'd7, 12'h008);
        start = swap_cnt;
        requestSwap();
        completeSwap("level8 swap", start);
        on_cnt = 0;
        for (int h = 0; h < 16; h++) begin
            sf = {h[3:0], 4'($urandom_range(0, 15))};
            readPixel(6'd20, 5'd7, sf, r0, r1);
            on_cnt += int'(r0[0]);
            checkOutput($sformatf("level8 sf%0h", sf), r0, exp_bits(12'h008, sf));
        end
        checkOutput("level8 on count", on_cnt, 8);

        // Writes to the back bank leave the display alone until the swap
        writePixel(6'd7, 6'd9, 12'hABC);
        checkModelPixel("display before swap", 6'd7, 5'd9, 8'h90);
        start = swap_cnt;
        requestSwap();
        repeat (20) @(negedge clk);
        checkOutput("frame held no swap", swap_cnt - start, 0);
        checkModelPixel("display during wait", 6'd7, 5'd9, 8'h90);
        completeSwap("display swap", start);
        checkModelPixel("display after swap", 6'd7, 5'd9, 8'h90);

        // Random writes then random reads through the model
        for (int i = 0; i < 40; i++) begin
            rx = 6'($urandom_range(0, 63));
            ry = 6'($urandom_range(0, 63));
            rv = $urandom;
            writePixel(rx, ry, rv[11:0]);
            rnd_px.push_back({ry, rx});
        end
        start = swap_cnt;
        requestSwap();
        completeSwap("random swap", start);
        for (int i = 0; i < 40; i++) begin
            sf = 8'($urandom_range(0, 255));
            checkModelPixel($sformatf("random%0d", i), rnd_px[i][5:0], rnd_px[i][10:6], sf);
        end

        // Reset inside SWAP_WAIT aborts the swap, front returns to bank 0
        if (model_front) begin
            start = swap_cnt;
            requestSwap();
            completeSwap("pre-reset swap", start);
        end
        writePixel(6'd1, 6'd1, 12'hFFF);
        start = swap_cnt;
        requestSwap();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        frame = frame + 13'd1;
        #1;
        checkOutput("swap_done during reset", bus.swap_done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_front = 1'b0;
        #1;
        checkOutput("wr_ready after reset", bus.wr_ready, 1);
        checkOutput("swap_done after reset", bus.swap_done, 0);
        repeat (2) @(negedge clk);
        frame = frame + 13'd1;
        repeat (3) @(negedge clk);
        checkOutput("no swap after reset", swap_cnt - start, 0);
        checkModelPixel("front after reset", 6'd1, 5'd1, 8'hE0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
